// File: rtl/button_bank.sv
// button_bank: multi-channel push-button front end.
// Each channel synchronises a raw button level, debounces it, and emits
// registered press/release/long-press/auto-repeat single-cycle pulses.
module button_bank #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] button_in,
    input  logic [NUM_BTN-1:0] repeat_en,
    output logic [NUM_BTN-1:0] btn_state,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [NUM_BTN-1:0] long_pulse,
    output logic [NUM_BTN-1:0] repeat_pulse
);

    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_LONG = 2'd2
    } hold_state_t;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
        logic              r_sync1;
        logic              r_sync2;
        logic              r_state;
        logic [DB_W-1:0]   r_db_cnt;
        logic              w_toggle;
        logic              w_rise;
        logic              w_fall;
        hold_state_t       r_hst;
        hold_state_t       w_hst_nxt;
        logic [HOLD_W-1:0] r_hold_cnt;
        logic [HOLD_W-1:0] w_hold_nxt;
        logic              w_long_nxt;
        logic              w_rep_nxt;
        logic              r_press;
        logic              r_release;
        logic              r_long;
        logic              r_repeat;

        // The debounced level flips on this edge when the disagreement has lasted long enough.
        assign w_toggle = (r_sync2 != r_state) && (r_db_cnt == DB_LAST);
        assign w_rise   = w_toggle && !r_state;
        assign w_fall   = w_toggle &&  r_state;

        // Two-flop synchroniser for the asynchronous pin.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
            end else begin
                r_sync1 <= button_in[gi];
                r_sync2 <= r_sync1;
            end
        end

        // Debounce: count consecutive disagreement, any agreement restarts it.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_state  <= 1'b0;
                r_db_cnt <= '0;
            end else if (r_sync2 == r_state) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_state  <= ~r_state;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_ONE;
            end
        end

        // Press/release pulses are registered alongside the level change.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= w_rise;
                r_release <= w_fall;
            end
        end

        // Hold FSM state, counter and registered long/repeat pulses.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_hst      <= S_IDLE;
                r_hold_cnt <= '0;
                r_long     <= 1'b0;
                r_repeat   <= 1'b0;
            end else begin
                r_hst      <= w_hst_nxt;
                r_hold_cnt <= w_hold_nxt;
                r_long     <= w_long_nxt;
                r_repeat   <= w_rep_nxt;
            end
        end

        // Hold FSM next state; a release always wins so pulse types never coincide.
        always_comb begin
            w_hst_nxt  = r_hst;
            w_hold_nxt = r_hold_cnt;
            w_long_nxt = 1'b0;
            w_rep_nxt  = 1'b0;
            case (r_hst)
                S_IDLE: begin
                    w_hold_nxt = '0;
                    if (w_rise) begin
                        w_hst_nxt = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_fall) begin
                        w_hst_nxt  = S_IDLE;
                        w_hold_nxt = '0;
                    end else if (r_hold_cnt == LONG_LAST) begin
                        w_long_nxt = 1'b1;
                        w_hold_nxt = '0;
                        w_hst_nxt  = S_LONG;
                    end else begin
                        w_hold_nxt = r_hold_cnt + HOLD_ONE;
                    end
                end
                S_LONG: begin
                    if (w_fall) begin
                        w_hst_nxt  = S_IDLE;
                        w_hold_nxt = '0;
                    end else if (!repeat_en[gi]) begin
                        w_hold_nxt = '0;
                    end else if (r_hold_cnt == REP_LAST) begin
                        w_rep_nxt  = 1'b1;
                        w_hold_nxt = '0;
                    end else begin
                        w_hold_nxt = r_hold_cnt + HOLD_ONE;
                    end
                end
                default: begin
                    w_hst_nxt  = S_IDLE;
                    w_hold_nxt = '0;
                end
            endcase
        end

        assign btn_state[gi]     = r_state;
        assign press_pulse[gi]   = r_press;
        assign release_pulse[gi] = r_release;
        assign long_pulse[gi]    = r_long;
        assign repeat_pulse[gi]  = r_repeat;
    end

endmodule

// File: tb/tb_button_bank.sv
// Testbench for button_bank: directed scenarios plus a random phase,
// every cycle compared against a timestamp-based reference model.
module tb_button_bank;

    localparam int NB = 4;
    localparam int D  = 4;
    localparam int L  = 16;
    localparam int R  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NB-1:0] button_in = '0;
    logic [NB-1:0] repeat_en = '0;
    logic [NB-1:0] btn_state;
    logic [NB-1:0] press_pulse;
    logic [NB-1:0] release_pulse;
    logic [NB-1:0] long_pulse;
    logic [NB-1:0] repeat_pulse;

    button_bank #(
        .NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R)
    ) dut (
        .clk(clk), .reset(reset), .button_in(button_in), .repeat_en(repeat_en),
        .btn_state(btn_state), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: raw samples per edge plus event timestamps per channel.
    logic [NB-1:0] samp [0:8191];
    int            n = 8;
    logic [NB-1:0] m_state, m_press, m_rel, m_long, m_rep;
    int            press_edge [NB];
    int            anchor     [NB];
    bit            held       [NB];
    bit            long_done  [NB];

    task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_clear();
        m_state = '0; m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
        for (int c = 0; c < NB; c++) begin
            held[c] = 1'b0; long_done[c] = 1'b0; press_edge[c] = 0; anchor[c] = 0;
        end
    endtask

    // A level is accepted when the D samples that reached the synchroniser output
    // (taken 2..D+1 edges ago) all differ from the current debounced level.
    task automatic model_edge();
        logic [NB-1:0] v;
        bit            diff;
        n++;
        if (!reset) begin
            samp[n] = '0;
            model_clear();
            return;
        end
        samp[n] = button_in;
        m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
        for (int c = 0; c < NB; c++) begin
            diff = 1'b1;
            for (int k = 2; k <= D + 1; k++) begin
                v = samp[n-k];
                if (v[c] == m_state[c]) diff = 1'b0;
            end
            if (diff && !m_state[c]) begin
                m_press[c] = 1'b1; held[c] = 1'b1; long_done[c] = 1'b0; press_edge[c] = n;
            end else if (diff && m_state[c]) begin
                m_rel[c] = 1'b1; held[c] = 1'b0; long_done[c] = 1'b0;
            end else if (held[c] && !long_done[c]) begin
                if (n - press_edge[c] == L) begin
                    m_long[c] = 1'b1; long_done[c] = 1'b1; anchor[c] = n;
                end
            end else if (held[c] && long_done[c]) begin
                if (!repeat_en[c]) anchor[c] = n;
                else if (n - anchor[c] == R) begin
                    m_rep[c] = 1'b1; anchor[c] = n;
                end
            end
            if (diff) m_state[c] = ~m_state[c];
        end
    endtask

    task automatic check_all();
        chk("btn_state", btn_state, m_state);
        chk("press_pulse", press_pulse, m_press);
        chk("release_pulse", release_pulse, m_rel);
        chk("long_pulse", long_pulse, m_long);
        chk("repeat_pulse", repeat_pulse, m_rep);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Wait (bounded) for a press pulse on channel c.
    task automatic wait_press(input int c, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (press_pulse[c]) found = 1'b1;
        end
        chk(tag, {3'b0, found}, 4'h1);
    endtask

    initial begin
        int            cnt0;
        int            run;
        logic [NB-1:0] e_long, e_rep, e_rel;

        for (int i = 0; i < 8192; i++) samp[i] = '0;
        model_clear();

        // Reset with all buttons held: outputs stay quiet.
        button_in = 4'hF;
        repeat (4) tick();
        chk("rst_state", btn_state, 4'h0);
        chk("rst_press", press_pulse, 4'h0);
        reset = 1'b1;
        repeat (5) tick();
        chk("rst_press_early", press_pulse, 4'h0);
        tick();
        chk("rst_press6", press_pulse, 4'hF);
        button_in = 4'h0;
        repeat (12) tick();
        chk("rst_released", btn_state, 4'h0);

        // Bounce on ch0 shorter than the debounce window is rejected.
        cnt0 = 0;
        run  = 0;
        for (int i = 0; i < 40; i++) begin
            if (run == 0) begin
                button_in[0] = ~button_in[0];
                run = $urandom_range(1, 3);
            end
            run--;
            tick();
            cnt0 += int'(press_pulse[0]) + int'(release_pulse[0]) + int'(btn_state[0]);
        end
        button_in[0] = 1'b0;
        repeat (8) begin
            tick();
            cnt0 += int'(press_pulse[0]) + int'(release_pulse[0]) + int'(btn_state[0]);
        end
        chk("bounce_quiet", 4'(cnt0), 4'h0);

        // Clean short press of ch1: press then release, never long.
        button_in[1] = 1'b1;
        repeat (10) tick();
        button_in[1] = 1'b0;
        repeat (12) tick();
        chk("ch1_idle", btn_state, 4'h0);

        // Long hold of ch2 without repeat.
        button_in[2] = 1'b1;
        wait_press(2, "ch2_press");
        for (int t = 1; t <= 66; t++) begin
            tick();
            e_long = (t == 16) ? 4'h4 : 4'h0;
            chk("ch2_long", long_pulse, e_long);
            chk("ch2_norep", repeat_pulse, 4'h0);
        end
        button_in[2] = 1'b0;
        repeat (10) tick();

        // Auto-repeat on ch3, released so the last repeat lands at +40.
        repeat_en[3] = 1'b1;
        button_in[3] = 1'b1;
        wait_press(3, "ch3_press");
        for (int t = 1; t <= 48; t++) begin
            tick();
            if (t == 36) button_in[3] = 1'b0;
            e_long = (t == 16) ? 4'h8 : 4'h0;
            e_rep  = (t >= 20 && t <= 40 && (t % 4) == 0) ? 4'h8 : 4'h0;
            e_rel  = (t == 42) ? 4'h8 : 4'h0;
            chk("ch3_long", long_pulse, e_long);
            chk("ch3_rep", repeat_pulse, e_rep);
            chk("ch3_rel", release_pulse, e_rel);
        end
        repeat_en[3] = 1'b0;

        // Reset while ch2 is in its long-hold phase: silent abort.
        button_in[2] = 1'b1;
        wait_press(2, "ch2b_press");
        repeat (25) tick();
        reset = 1'b0;
        model_clear();
        #1;
        check_all();
        chk("midrst_state", btn_state, 4'h0);
        repeat (3) tick();
        button_in[2] = 1'b0;
        reset = 1'b1;
        cnt0 = 0;
        repeat (15) begin
            tick();
            cnt0 += int'(release_pulse[2]);
        end
        chk("midrst_norel", 4'(cnt0), 4'h0);

        // Random phase: slow random button activity and repeat enables.
        for (int i = 0; i < 900; i++) begin
            for (int c = 0; c < NB; c++) begin
                if ($urandom_range(0, 11) == 0) button_in[c] = ~button_in[c];
                if ($urandom_range(0, 39) == 0) repeat_en[c] = ~repeat_en[c];
            end
            if (i % 150 == 0) begin
                for (int c = 0; c < NB; c++)
                    if ($urandom_range(0, 1) == 1) button_in[c] = 1'b1;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
